tcdm_error_slave_mp: RTL
========================

# tcdm_error_slave_mp

Multi-port, parametrised TCDM error slave for the SoC interconnect's unmapped address ranges. It grants every request and returns a configurable error word after a configurable latency, asserting the opc error flag. It also keeps a sticky first-error log (address, port, read/write), a saturating error counter and an interrupt pulse, so software can diagnose illegal accesses after the fact.

## Interface
- NB_PORTS, default 1: number of independent TCDM slave ports (1..16).
- ADDR_WIDTH, default 32: address width per port.
- DATA_WIDTH, default 32: data width per port (multiple of 32).
- ERROR_RESPONSE, default 32'hBADACCE5: 32-bit pattern, replicated DATA_WIDTH/32 times on r_rdata.
- RESP_LATENCY, default 1: cycles from grant to r_valid (1..4).
- WRITE_IS_ERROR, default 1'b0: 1 means writes also assert r_opc; 0 means writes are acknowledged silently.
- CNT_WIDTH, default 16: width of the error counter.

Ports (clock and reset first):
- clk_i  in  1  clock.
- rst_i  in  1  reset. One clock; reset is synchronous and active-high.
- req_i  in  NB_PORTS  request per port.
- add_i  in  NB_PORTS x ADDR_WIDTH  request address.
- wen_i  in  NB_PORTS  1 = read, 0 = write.
- wdata_i  in  NB_PORTS x DATA_WIDTH  ignored.
- be_i  in  NB_PORTS x DATA_WIDTH/8  ignored.
- gnt_o  out  NB_PORTS  grant.
- r_valid_o  out  NB_PORTS  response valid.
- r_opc_o  out  NB_PORTS  bus error flag.
- r_rdata_o  out  NB_PORTS x DATA_WIDTH  response data.
- clr_i  in  1  clears the log, the overflow flag and the counter.
- log_valid_o  out  1  first-error log holds an entry.
- log_addr_o  out  ADDR_WIDTH  address of the first logged error.
- log_port_o  out  $clog2(NB_PORTS) (min 1)  port of the first logged error.
- log_wen_o  out  1  wen of the first logged error.
- log_ovf_o  out  1  at least one further error arrived while the log was valid.
- err_cnt_o  out  CNT_WIDTH  count of errors, saturating.
- irq_o  out  1  one-cycle pulse when log_valid_o rises.

## Operation
- The grant is combinational: gnt_o[p] = req_i[p], with no backpressure.
- Each port has an independent delay line of depth RESP_LATENCY. Each stage carries valid and wen, so back-to-back requests yield back-to-back responses.
- Response data: r_rdata_o[p] = replicated ERROR_RESPONSE when r_valid_o[p] is high and the access was a read. Otherwise r_rdata_o[p] = 0.
- r_opc_o[p] = r_valid_o[p] & (wen_of_access | WRITE_IS_ERROR).
- Error event: a granted read, or a granted write when WRITE_IS_ERROR = 1. Events are counted at request time, not at response time.
- Log capture:
  - If the log is empty and one or more ports have an event, capture the lowest-index port's address, port number and wen.
  - Set log_valid and pulse irq_o in the next cycle.
  - If the log is already valid and any event occurs, set log_ovf_o. The captured fields do not change.
- Counter: err_cnt += popcount(events) each cycle, saturating at 2^CNT_WIDTH-1. It never wraps.
- Clear: when clr_i is high, the log, overflow flag and counter are cleared, then events in that same cycle are applied. A same-cycle event is therefore captured fresh, the count equals that cycle's popcount, and irq_o pulses.
- No state machine beyond the log's EMPTY/VALID states: EMPTY goes to VALID on an event; VALID goes to EMPTY on clr_i without an event.

## Timing
- Reset values: r_valid_o = 0, r_opc_o = 0, r_rdata_o = 0, log_valid_o = 0, log_addr_o = 0, log_port_o = 0, log_wen_o = 0, log_ovf_o = 0, err_cnt_o = 0, irq_o = 0. gnt_o follows req_i at all times, including during reset.
- Latency: request granted in cycle t gives r_valid_o in cycle t+RESP_LATENCY. Throughput is one response per port per cycle.
- Log outputs, err_cnt_o and irq_o update in cycle t+1 for an event in cycle t.
- Reset mid-operation: every pipeline stage is flushed. No response for a pre-reset request appears after reset deasserts.
- All response outputs are registered. The only combinational path is gnt_o.

## Structure
- Package tcdm_err_pkg holds:
  - the default ERROR_RESPONSE constant;
  - the typedef err_log_t {valid, ovf, addr, port, wen} as a parameterised struct, or a struct plus width constants;
  - a popcount function.
- Sub-module tcdm_err_resp_pipe implements one port's valid/wen shift register of depth RESP_LATENCY. The top instantiates it NB_PORTS times.
- The top contains the priority encoder, the counter and the log registers.

## Test plan
- NB_PORTS=1, RESP_LATENCY=1: read to 0x1A10_0000 at t=5. Expect gnt_o=1 at t=5, and r_valid=1, r_opc=1, r_rdata=0xBADACCE5 at t=6. Expect log_addr=0x1A10_0000, log_valid=1 and irq_o pulse at t=6.
- WRITE_IS_ERROR=0: write, then read back-to-back. Expect the first response r_valid=1, r_opc=0, r_rdata=0 and the second r_opc=1. Expect err_cnt=1.
- NB_PORTS=4: reads on ports 3 and 1 in the same cycle. Expect log_port=1, err_cnt=2 and log_ovf=0. A third read the next cycle gives log_ovf=1, err_cnt=3, log unchanged.
- RESP_LATENCY=3, DATA_WIDTH=64: four consecutive reads. Expect four consecutive r_valid cycles starting 3 cycles after the first request, each with r_rdata=0xBADACCE5BADACCE5.
- CNT_WIDTH=4: 20 read events. Expect err_cnt stuck at 15. Assert clr_i together with a read on port 0: expect err_cnt=1, log_valid=1 and an irq_o pulse.
- Assert rst_i for one cycle with two reads in flight (RESP_LATENCY=2). Expect no r_valid afterwards, and all log and counter outputs at 0.

Source files
------------

// File: rtl/tcdm_err_pkg.sv
// Shared types and helpers for the TCDM error slave: default error word,
// first-error log record and a popcount used by the error counter.
package tcdm_err_pkg;

  localparam logic [31:0] ERROR_RESPONSE_DEFAULT = 32'hBADACCE5;

  // Log fields are sized for the widest supported port (64-bit address,
  // 16 ports); the top keeps only the low bits it needs.
  localparam int unsigned LOG_ADDR_WIDTH = 64;
  localparam int unsigned LOG_PORT_WIDTH = 4;

  typedef struct packed {
    logic                      valid;
    logic                      ovf;
    logic [LOG_ADDR_WIDTH-1:0] addr;
    logic [LOG_PORT_WIDTH-1:0] port;
    logic                      wen;
  } err_log_t;

  function automatic logic [4:0] popcount(input logic [15:0] vec);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(vec[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/tcdm_err_resp_pipe.sv
// One port's response delay line: valid and wen shifted through LATENCY
// stages so back-to-back requests give back-to-back responses.
module tcdm_err_resp_pipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  input  logic wen_i,
  output logic valid_o,
  output logic wen_o
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] wen_q;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value and the chain really shifts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int i = 1; i < LATENCY; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: wen is only meaningful alongside valid, so it is a plain data
  // stage without reset; flushing valid alone kills in-flight responses.
  always_ff @(posedge clk_i) begin
    wen_q[0] <= wen_i;
    for (int i = 1; i < LATENCY; i++) wen_q[i] <= wen_q[i-1];
  end

  assign valid_o = valid_q[LATENCY-1];
  assign wen_o   = wen_q[LATENCY-1];

endmodule

// File: rtl/tcdm_error_slave_mp.sv
// Multi-port TCDM error slave: grants everything, answers with an error word,
// and keeps a sticky first-error log, a saturating counter and an irq pulse.
module tcdm_error_slave_mp
  import tcdm_err_pkg::*;
#(
  parameter int unsigned NB_PORTS       = 1,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [31:0] ERROR_RESPONSE = ERROR_RESPONSE_DEFAULT,
  parameter int unsigned RESP_LATENCY   = 1,
  parameter logic        WRITE_IS_ERROR = 1'b0,
  parameter int unsigned CNT_WIDTH      = 16,
  localparam int unsigned PORT_W        = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NB_PORTS-1:0]                   req_i,
  input  logic [NB_PORTS-1:0][ADDR_WIDTH-1:0]   add_i,
  input  logic [NB_PORTS-1:0]                   wen_i,
  input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
  input  logic [NB_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
  output logic [NB_PORTS-1:0]                   gnt_o,
  output logic [NB_PORTS-1:0]                   r_valid_o,
  output logic [NB_PORTS-1:0]                   r_opc_o,
  output logic [NB_PORTS-1:0][DATA_WIDTH-1:0]   r_rdata_o,
  input  logic                                  clr_i,
  output logic                                  log_valid_o,
  output logic [ADDR_WIDTH-1:0]                 log_addr_o,
  output logic [PORT_W-1:0]                     log_port_o,
  output logic                                  log_wen_o,
  output logic                                  log_ovf_o,
  output logic [CNT_WIDTH-1:0]                  err_cnt_o,
  output logic                                  irq_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam int unsigned          SUM_W   = CNT_WIDTH + 5;

  logic [NB_PORTS-1:0] pipe_valid;
  logic [NB_PORTS-1:0] pipe_wen;
  logic [NB_PORTS-1:0] event_vec;

  err_log_t             log_q, log_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_base;
  logic [SUM_W-1:0]     cnt_sum;
  logic                 irq_q, irq_d;
  logic [PORT_W-1:0]    first_port;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic                 first_wen;

  assign gnt_o = req_i;

  for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
    tcdm_err_resp_pipe #(
      .LATENCY (RESP_LATENCY)
    ) u_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (req_i[p]),
      .wen_i   (wen_i[p]),
      .valid_o (pipe_valid[p]),
      .wen_o   (pipe_wen[p])
    );

    assign r_valid_o[p] = pipe_valid[p];
    assign r_opc_o[p]   = pipe_valid[p] & (pipe_wen[p] | WRITE_IS_ERROR);
    assign r_rdata_o[p] = (pipe_valid[p] & pipe_wen[p]) ?
                          {(DATA_WIDTH/32){ERROR_RESPONSE}} : '0;
  end

  assign event_vec = req_i & (wen_i | {NB_PORTS{WRITE_IS_ERROR}});

  // NOTE: every variable gets its default before any branch, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    log_d      = clr_i ? '0 : log_q;
    cnt_base   = clr_i ? '0 : cnt_q;
    irq_d      = 1'b0;
    first_port = '0;
    first_addr = '0;
    first_wen  = 1'b0;

    // Scan downwards so the lowest-index active port wins.
    for (int p = NB_PORTS - 1; p >= 0; p--) begin
      if (event_vec[p]) begin
        first_port = PORT_W'(p);
        first_addr = add_i[p];
        first_wen  = wen_i[p];
      end
    end

    if (|event_vec) begin
      if (!log_d.valid) begin
        log_d.valid = 1'b1;
        log_d.addr  = LOG_ADDR_WIDTH'(first_addr);
        log_d.port  = LOG_PORT_WIDTH'(first_port);
        log_d.wen   = first_wen;
        irq_d       = 1'b1;
      end else begin
        log_d.ovf = 1'b1;
      end
    end

    cnt_sum = SUM_W'(cnt_base) + SUM_W'(popcount(16'(event_vec)));
    cnt_d   = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      log_q <= '0;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      log_q <= log_d;
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign log_valid_o = log_q.valid;
  assign log_addr_o  = log_q.addr[ADDR_WIDTH-1:0];
  assign log_port_o  = log_q.port[PORT_W-1:0];
  assign log_wen_o   = log_q.wen;
  assign log_ovf_o   = log_q.ovf;
  assign err_cnt_o   = cnt_q;
  assign irq_o       = irq_q;

  // Write data, byte enables and the spare log bits are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{wdata_i, be_i, log_q};

endmodule
